// File: rtl/gmii_frame_tx.sv
// gmii_frame_tx: turns a valid/ready/last byte stream into GMII frames.
// Each frame is preamble, SFD, payload (zero-padded to MIN_PAYLOAD), then a
// 4-byte Ethernet FCS, followed by at least IFG_CYCLES cycles with rx_dv low.
// Every output comes straight from a register.
module gmii_frame_tx #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 60,
  parameter int IFG_CYCLES   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  rxd,
  output logic        rx_dv,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] frame_cnt
);

  localparam logic [31:0] CRC_POLY  = 32'hEDB88320;
  localparam logic [15:0] MIN_PAY16 = 16'(MIN_PAYLOAD);
  localparam logic [3:0]  PRE_LAST  = 4'(PREAMBLE_LEN);
  localparam logic [7:0]  IFG_LAST  = 8'(IFG_CYCLES);

  // State names describe what is on rxd during the current cycle.
  typedef enum logic [2:0] {
    IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, DRAIN, IFG
  } state_t;

  // One byte of the reflected CRC-32, LSB of the data first.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

  // Payload byte counter saturates rather than wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // FCS byte idx (0 = least significant) of the final, inverted CRC.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
    logic [31:0] fcs;
    fcs = ~crc >> {idx, 3'b000};
    return fcs[7:0];
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [15:0] pay_cnt_q, pay_cnt_d;
  logic [1:0]  fcs_idx_q, fcs_idx_d;
  logic [7:0]  ifg_cnt_q, ifg_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  rxd_q, rxd_d;
  logic        rx_dv_q, rx_dv_d;
  logic        s_ready_q, s_ready_d;
  logic        busy_q, busy_d;
  logic        underrun_q, underrun_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        start;

  // Next-state and next-output computation for the framing FSM.
  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    pay_cnt_d   = pay_cnt_q;
    fcs_idx_d   = fcs_idx_q;
    ifg_cnt_d   = ifg_cnt_q;
    crc_d       = crc_q;
    rxd_d       = 8'h00;
    rx_dv_d     = 1'b0;
    s_ready_d   = 1'b0;
    underrun_d  = 1'b0;
    frame_cnt_d = frame_cnt_q;

    // The final IFG cycle counts as satisfied, so a waiting source starts
    // its preamble right after exactly IFG_CYCLES low cycles.
    start = s_valid && ((state_q == IDLE) ||
                        ((state_q == IFG) && (ifg_cnt_q == IFG_LAST)));

    unique case (state_q)
      IDLE: begin
      end

      PREAMBLE: begin
        rx_dv_d = 1'b1;
        if (pre_cnt_q == PRE_LAST) begin
          state_d   = SFD;
          rxd_d     = 8'hD5;
          s_ready_d = 1'b1;
        end else begin
          pre_cnt_d = pre_cnt_q + 4'd1;
          rxd_d     = 8'h55;
        end
      end

      // s_ready_q low in PAYLOAD means the last payload byte is on the wire.
      SFD, PAYLOAD: begin
        if (s_ready_q) begin
          if (s_valid) begin
            state_d   = PAYLOAD;
            rxd_d     = s_data;
            rx_dv_d   = 1'b1;
            crc_d     = crc_step(crc_q, s_data);
            pay_cnt_d = sat_inc(pay_cnt_q);
            s_ready_d = ~s_last;
          end else begin
            state_d    = DRAIN;
            s_ready_d  = 1'b1;
            underrun_d = 1'b1;
          end
        end else if (pay_cnt_q < MIN_PAY16) begin
          state_d   = PAD;
          rx_dv_d   = 1'b1;
          crc_d     = crc_step(crc_q, 8'h00);
          pay_cnt_d = sat_inc(pay_cnt_q);
        end else begin
          state_d   = FCS;
          fcs_idx_d = 2'd0;
          rxd_d     = fcs_byte(crc_q, 2'd0);
          rx_dv_d   = 1'b1;
        end
      end

      PAD: begin
        rx_dv_d = 1'b1;
        if (pay_cnt_q < MIN_PAY16) begin
          crc_d     = crc_step(crc_q, 8'h00);
          pay_cnt_d = sat_inc(pay_cnt_q);
        end else begin
          state_d   = FCS;
          fcs_idx_d = 2'd0;
          rxd_d     = fcs_byte(crc_q, 2'd0);
        end
      end

      // Frame is counted on the same edge that puts the last FCS byte out.
      FCS: begin
        if (fcs_idx_q == 2'd3) begin
          state_d   = IFG;
          ifg_cnt_d = 8'd1;
        end else begin
          fcs_idx_d = fcs_idx_q + 2'd1;
          rxd_d     = fcs_byte(crc_q, fcs_idx_q + 2'd1);
          rx_dv_d   = 1'b1;
          if (fcs_idx_q == 2'd2) frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end

      // Swallow the rest of an aborted frame without putting it on the wire.
      DRAIN: begin
        s_ready_d = 1'b1;
        if (s_valid && s_last) begin
          state_d   = IFG;
          ifg_cnt_d = 8'd1;
          s_ready_d = 1'b0;
        end
      end

      IFG: begin
        if (ifg_cnt_q == IFG_LAST) state_d = IDLE;
        else                       ifg_cnt_d = ifg_cnt_q + 8'd1;
      end

      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d   = PREAMBLE;
      pre_cnt_d = 4'd1;
      pay_cnt_d = 16'd0;
      crc_d     = 32'hFFFFFFFF;
      rxd_d     = 8'h55;
      rx_dv_d   = 1'b1;
    end
  end

  assign busy_d = (state_d != IDLE);

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pre_cnt_q   <= 4'd0;
      pay_cnt_q   <= 16'd0;
      fcs_idx_q   <= 2'd0;
      ifg_cnt_q   <= 8'd0;
      crc_q       <= 32'hFFFFFFFF;
      rxd_q       <= 8'h00;
      rx_dv_q     <= 1'b0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      pay_cnt_q   <= pay_cnt_d;
      fcs_idx_q   <= fcs_idx_d;
      ifg_cnt_q   <= ifg_cnt_d;
      crc_q       <= crc_d;
      rxd_q       <= rxd_d;
      rx_dv_q     <= rx_dv_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign rxd       = rxd_q;
  assign rx_dv     = rx_dv_q;
  assign busy      = busy_q;
  assign underrun  = underrun_q;
  assign frame_cnt = frame_cnt_q;

endmodule
